// File: rtl/mutex_rule_scheduler_pkg.sv
// Shared types and helpers for the mutual-exclusion rule scheduler:
// node states, rule indices, rule-code encode/decode and the FSM state enum.
package mutex_rule_scheduler_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_T = 2'd1,
    ST_C = 2'd2,
    ST_E = 2'd3
  } node_state_e;

  typedef enum logic [1:0] {
    RULE_TRY  = 2'd0,
    RULE_CRIT = 2'd1,
    RULE_EXIT = 2'd2,
    RULE_IDLE = 2'd3
  } rule_e;

  typedef enum logic [1:0] {
    S_EVAL  = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } sched_state_e;

  // Codes are 1-based: rule r on node i maps to 1 + nodes*r + i; 0 means no rule.
  function automatic logic [CODE_W-1:0] rule_code(input rule_e r, input int node, input int nodes);
    return CODE_W'(1 + int'(r) * nodes + node);
  endfunction

  function automatic rule_e code_rule(input logic [CODE_W-1:0] code, input int nodes);
    return rule_e'(2'((int'(code) - 1) / nodes));
  endfunction

  function automatic int code_node(input logic [CODE_W-1:0] code, input int nodes);
    return (int'(code) - 1) % nodes;
  endfunction

endpackage

// File: rtl/mutex_guard_eval.sv
// Combinational guard evaluation: one enable bit per rule code, bit index = code-1.
module mutex_guard_eval
  import mutex_rule_scheduler_pkg::*;
#(
  parameter int NODES = 3
) (
  input  logic [2*NODES-1:0] n_i,
  input  logic               x_i,
  output logic [4*NODES-1:0] enabled_o
);

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    localparam int TRY_BIT  = int'(rule_code(RULE_TRY,  gi, NODES)) - 1;
    localparam int CRIT_BIT = int'(rule_code(RULE_CRIT, gi, NODES)) - 1;
    localparam int EXIT_BIT = int'(rule_code(RULE_EXIT, gi, NODES)) - 1;
    localparam int IDLE_BIT = int'(rule_code(RULE_IDLE, gi, NODES)) - 1;

    logic [1:0] node_st;
    assign node_st = n_i[2*gi +: 2];

    assign enabled_o[TRY_BIT]  = (node_st == ST_I);
    assign enabled_o[CRIT_BIT] = (node_st == ST_T) && x_i;
    assign enabled_o[EXIT_BIT] = (node_st == ST_C);
    assign enabled_o[IDLE_BIT] = (node_st == ST_E);
  end

endmodule

// File: rtl/mutex_rule_scheduler.sv
// Rule-select driver for the mutual-exclusion core: round-robin pick among enabled
// rules with host override, one rule per two cycles, sticky deadlock detection.
module mutex_rule_scheduler
  import mutex_rule_scheduler_pkg::*;
#(
  parameter int NODES          = 3,
  parameter int DEADLOCK_LIMIT = 4,
  parameter int CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2*NODES-1:0] io_n,
  input  logic               io_x,
  input  logic               io_run,
  input  logic               io_force_valid,
  input  logic [CODE_W-1:0]  io_force_code,
  output logic [CODE_W-1:0]  io_en_a,
  output logic               io_bad_force,
  output logic               io_deadlock,
  output logic [CNT_W-1:0]   io_fired
);

  localparam int NUM_CODES = 4 * NODES;
  localparam int DLW       = $clog2(DEADLOCK_LIMIT + 1);

  sched_state_e      state_q;
  logic [CODE_W-1:0] en_a_q;
  logic [CODE_W-1:0] ptr_q;
  logic              bad_force_q;
  logic              deadlock_q;
  logic [CNT_W-1:0]  fired_q;
  logic [CNT_W-1:0]  fired_d;
  logic [DLW-1:0]    dl_cnt_q;
  logic [DLW-1:0]    dl_cnt_d;

  logic [NUM_CODES-1:0] enabled;
  logic [15:0]          enabled_pad;
  logic                 force_ok;
  logic                 pick_valid;
  logic [CODE_W-1:0]    pick_code;
  logic [CODE_W-1:0]    scan;

  mutex_guard_eval #(
    .NODES(NODES)
  ) u_guard (
    .n_i      (io_n),
    .x_i      (io_x),
    .enabled_o(enabled)
  );

  assign enabled_pad = 16'(enabled);

  // Out-of-range codes never index a real guard, so they are rejected up front.
  assign force_ok = (io_force_code != '0)
                 && (io_force_code <= CODE_W'(NUM_CODES))
                 && enabled_pad[io_force_code - 4'd1];

  always_comb begin
    pick_valid = 1'b0;
    pick_code  = '0;
    scan       = ptr_q;
    for (int k = 0; k < NUM_CODES; k++) begin
      scan = (scan == CODE_W'(NUM_CODES)) ? CODE_W'(1) : scan + CODE_W'(1);
      if (!pick_valid && enabled_pad[scan - 4'd1]) begin
        pick_valid = 1'b1;
        pick_code  = scan;
      end
    end
  end

  assign fired_d  = (&fired_q) ? fired_q : fired_q + CNT_W'(1);
  assign dl_cnt_d = (dl_cnt_q == DLW'(DEADLOCK_LIMIT)) ? dl_cnt_q : dl_cnt_q + DLW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_EVAL;
      en_a_q      <= '0;
      ptr_q       <= CODE_W'(NUM_CODES);
      bad_force_q <= 1'b0;
      deadlock_q  <= 1'b0;
      fired_q     <= '0;
      dl_cnt_q    <= '0;
    end else begin
      bad_force_q <= 1'b0;
      case (state_q)
        S_EVAL: begin
          en_a_q <= '0;
          if (io_run) begin
            if (io_force_valid) begin
              if (force_ok) begin
                en_a_q  <= io_force_code;
                state_q <= S_ISSUE;
              end else begin
                bad_force_q <= 1'b1;
              end
            end else if (pick_valid) begin
              en_a_q   <= pick_code;
              ptr_q    <= pick_code;
              dl_cnt_q <= '0;
              state_q  <= S_ISSUE;
            end else begin
              dl_cnt_q <= dl_cnt_d;
              if (dl_cnt_d == DLW'(DEADLOCK_LIMIT)) begin
                deadlock_q <= 1'b1;
                state_q    <= S_HALT;
              end
            end
          end
        end
        S_ISSUE: begin
          en_a_q  <= '0;
          fired_q <= fired_d;
          state_q <= S_EVAL;
        end
        S_HALT: begin
          en_a_q <= '0;
        end
        default: begin
          en_a_q  <= '0;
          state_q <= S_EVAL;
        end
      endcase
    end
  end

  assign io_en_a      = en_a_q;
  assign io_bad_force = bad_force_q;
  assign io_deadlock  = deadlock_q;
  assign io_fired     = fired_q;

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Directed bench for mutex_rule_scheduler with a tiny closed-loop core model.
module tb_mutex_rule_scheduler;

  localparam logic [1:0] NI = 2'd0;
  localparam logic [1:0] NT = 2'd1;
  localparam logic [1:0] NC = 2'd2;
  localparam logic [1:0] NE = 2'd3;

  logic        clock;
  logic        reset;
  logic [5:0]  io_n;
  logic        io_x;
  logic        io_run;
  logic        io_force_valid;
  logic [3:0]  io_force_code;
  logic [3:0]  io_en_a;
  logic        io_bad_force;
  logic        io_deadlock;
  logic [15:0] io_fired;

  int checks = 0;
  int errors = 0;

  mutex_rule_scheduler #(
    .NODES(3),
    .DEADLOCK_LIMIT(4),
    .CNT_W(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_n          (io_n),
    .io_x          (io_x),
    .io_run        (io_run),
    .io_force_valid(io_force_valid),
    .io_force_code (io_force_code),
    .io_en_a       (io_en_a),
    .io_bad_force  (io_bad_force),
    .io_deadlock   (io_deadlock),
    .io_fired      (io_fired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_nodes(input logic [1:0] n0, input logic [1:0] n1, input logic [1:0] n2);
    io_n = {n2, n1, n0};
  endtask

  // Core effect of a rule: Try I->T, Crit T->C (takes token), Exit C->E, Idle E->I (returns token).
  task automatic apply_rule(input logic [3:0] code);
    int c;
    int r;
    int i;
    c = int'(code) - 1;
    r = c / 3;
    i = c % 3;
    case (r)
      0: io_n[2*i +: 2] = NT;
      1: begin io_n[2*i +: 2] = NC; io_x = 1'b0; end
      2: io_n[2*i +: 2] = NE;
      default: begin io_n[2*i +: 2] = NI; io_x = 1'b1; end
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1;
    io_run = 1'b0;
    io_force_valid = 1'b0;
    io_force_code = 4'd0;
    io_x = 1'b0;
    set_nodes(NI, NI, NI);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL reset_en_a got %0d expected 0", io_en_a); end
    checks++; if (io_bad_force !== 1'b0) begin errors++; $display("FAIL reset_bad_force got %0b expected 0", io_bad_force); end
    checks++; if (io_deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock got %0b expected 0", io_deadlock); end
    checks++; if (io_fired !== 16'd0) begin errors++; $display("FAIL reset_fired got %0d expected 0", io_fired); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_seq [0:5];
    exp_seq = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3};
    set_nodes(NI, NI, NI);
    io_x = 1'b1;
    io_run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      $display("rr cycle %0d en_a=%0d", k + 1, io_en_a);
      checks++;
      if (io_en_a !== exp_seq[k]) begin
        errors++;
        $display("FAIL rr_en_a cycle %0d got %0d expected %0d", k + 1, io_en_a, exp_seq[k]);
      end
      if (io_en_a != 4'd0) apply_rule(io_en_a);
      @(negedge clock);
    end
    io_run = 1'b0;
    checks++; if (io_fired !== 16'd3) begin errors++; $display("FAIL rr_fired got %0d expected 3", io_fired); end
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL rr_idle_en_a got %0d expected 0", io_en_a); end
  endtask

  // n stays (T,T,T), x=1 and ptr=3 from the round-robin walk.
  task automatic test_force_ok;
    set_nodes(NT, NT, NT);
    io_x = 1'b1;
    io_run = 1'b1;
    io_force_valid = 1'b1;
    io_force_code = 4'd4;
    @(negedge clock);
    $display("force4 en_a=%0d bad=%0b", io_en_a, io_bad_force);
    checks++; if (io_en_a !== 4'd4) begin errors++; $display("FAIL force_ok_en_a got %0d expected 4", io_en_a); end
    checks++; if (io_bad_force !== 1'b0) begin errors++; $display("FAIL force_ok_bad got %0b expected 0", io_bad_force); end
    io_force_valid = 1'b0;
    @(negedge clock);
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL force_ok_gap got %0d expected 0", io_en_a); end
    checks++; if (io_fired !== 16'd4) begin errors++; $display("FAIL force_ok_fired got %0d expected 4", io_fired); end
    @(negedge clock);
    $display("free pick after force en_a=%0d", io_en_a);
    checks++; if (io_en_a !== 4'd4) begin errors++; $display("FAIL force_ptr_kept got %0d expected 4", io_en_a); end
    io_run = 1'b0;
    @(negedge clock);
    checks++; if (io_fired !== 16'd5) begin errors++; $display("FAIL force_free_fired got %0d expected 5", io_fired); end
  endtask

  task automatic test_force_bad;
    set_nodes(NT, NT, NT);
    io_x = 1'b0;
    io_run = 1'b1;
    io_force_valid = 1'b1;
    io_force_code = 4'd4;
    @(negedge clock);
    $display("force4 x=0 en_a=%0d bad=%0b", io_en_a, io_bad_force);
    checks++; if (io_bad_force !== 1'b1) begin errors++; $display("FAIL bad4_pulse got %0b expected 1", io_bad_force); end
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL bad4_en_a got %0d expected 0", io_en_a); end
    io_run = 1'b0;
    io_force_valid = 1'b0;
    @(negedge clock);
    checks++; if (io_bad_force !== 1'b0) begin errors++; $display("FAIL bad4_one_cycle got %0b expected 0", io_bad_force); end
    checks++; if (io_fired !== 16'd5) begin errors++; $display("FAIL bad4_fired got %0d expected 5", io_fired); end
    set_nodes(NI, NI, NI);
    io_x = 1'b1;
    io_run = 1'b1;
    io_force_valid = 1'b1;
    io_force_code = 4'd14;
    @(negedge clock);
    $display("force14 en_a=%0d bad=%0b", io_en_a, io_bad_force);
    checks++; if (io_bad_force !== 1'b1) begin errors++; $display("FAIL bad14_pulse got %0b expected 1", io_bad_force); end
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL bad14_en_a got %0d expected 0", io_en_a); end
    io_run = 1'b0;
    io_force_valid = 1'b0;
    @(negedge clock);
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL bad14_no_issue got %0d expected 0", io_en_a); end
    checks++; if (io_fired !== 16'd5) begin errors++; $display("FAIL bad14_fired got %0d expected 5", io_fired); end
  endtask

  task automatic test_force_while_stopped;
    io_run = 1'b0;
    io_force_valid = 1'b1;
    io_force_code = 4'd1;
    repeat (2) begin
      @(negedge clock);
      checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL stopped_en_a got %0d expected 0", io_en_a); end
      checks++; if (io_bad_force !== 1'b0) begin errors++; $display("FAIL stopped_bad got %0b expected 0", io_bad_force); end
    end
    io_force_valid = 1'b0;
  endtask

  task automatic test_deadlock;
    set_nodes(NT, NT, NT);
    io_x = 1'b0;
    io_run = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (io_deadlock !== 1'b0) begin errors++; $display("FAIL dl_early got %0b expected 0", io_deadlock); end
    @(negedge clock);
    $display("deadlock after 4 evals=%0b", io_deadlock);
    checks++; if (io_deadlock !== 1'b1) begin errors++; $display("FAIL dl_rise got %0b expected 1", io_deadlock); end
    set_nodes(NI, NI, NI);
    io_x = 1'b1;
    io_force_valid = 1'b1;
    io_force_code = 4'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL halt_en_a cycle %0d got %0d expected 0", k, io_en_a); end
      checks++; if (io_deadlock !== 1'b1) begin errors++; $display("FAIL halt_sticky cycle %0d got %0b expected 1", k, io_deadlock); end
    end
    io_force_valid = 1'b0;
    io_run = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (io_deadlock !== 1'b0) begin errors++; $display("FAIL dl_reset got %0b expected 0", io_deadlock); end
    checks++; if (io_fired !== 16'd0) begin errors++; $display("FAIL dl_reset_fired got %0d expected 0", io_fired); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_issue;
    set_nodes(NC, NC, NC);
    io_x = 1'b0;
    io_run = 1'b1;
    @(negedge clock);
    $display("pre-reset issue en_a=%0d", io_en_a);
    checks++; if (io_en_a !== 4'd7) begin errors++; $display("FAIL mid_issue_en_a got %0d expected 7", io_en_a); end
    #1 reset = 1'b1;
    #1;
    checks++; if (io_en_a !== 4'd0) begin errors++; $display("FAIL async_drop got %0d expected 0", io_en_a); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("post-reset pick en_a=%0d", io_en_a);
    checks++; if (io_en_a !== 4'd7) begin errors++; $display("FAIL ptr_reset_pick got %0d expected 7", io_en_a); end
    io_run = 1'b0;
    @(negedge clock);
    checks++; if (io_fired !== 16'd1) begin errors++; $display("FAIL post_reset_fired got %0d expected 1", io_fired); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_force_ok();
    test_force_bad();
    test_force_while_stopped();
    test_deadlock();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mutex_rule_scheduler.md
# mutex_rule_scheduler

- Upstream driver of the mutual-exclusion `system` core: each cycle it decides which guarded rule instance the core fires, and drives the core's `io_en_a` rule-select input.
- Evaluates all rule guards against the core's current `n`/`x` state and chooses one enabled instance round-robin. A host-forced rule may override the choice.
- Reports a sticky deadlock flag and a fired-rule counter.
- Replaces hand-written or solver-generated stimulus when long random-walk simulation of the core is wanted.

## Interface
Parameters:
- NODES, 3: node count; rule codes must fit in 4 bits (4·NODES ≤ 15).
- DEADLOCK_LIMIT, 4: number of consecutive evaluations with no enabled rule before halting.
- CNT_W, 16: width of the fired-rule counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- io_n_i (i=0..NODES-1)  in  2  node state: I=0, T=1, C=2, E=3.
- io_x  in  1  shared token flag.
- io_run  in  1  scheduler enabled; 0 parks in EVAL issuing nothing.
- io_force_valid  in  1  host requests a specific rule this evaluation.
- io_force_code  in  4  requested rule code.
- io_en_a  out  4  rule select to core; 0 = no rule.
- io_bad_force  out  1  one-cycle pulse: forced rule's guard was false.
- io_deadlock  out  1  sticky; cleared only by reset.
- io_fired  out  CNT_W  count of issued rules, saturating.

## Operation
Rule code encoding:
- code = 1 + 3·r + i, for rule r (Try=0, Crit=1, Exit=2, Idle=3) and node i.
- Unused codes are 13–15, and 0.

Guards:
- Try(i): n_i==I.
- Crit(i): n_i==T && x.
- Exit(i): n_i==C.
- Idle(i): n_i==E.

The core applies the rule's effect. The scheduler only selects.

FSM states: EVAL, ISSUE, HALT. Reset state is EVAL.

EVAL (io_en_a=0):
- If !io_run: stay in EVAL; no counter changes.
- Else if io_force_valid:
  - Force guard true: latch io_force_code → ISSUE.
  - Force guard false, or code is 0 or >12: pulse io_bad_force, stay in EVAL. Round-robin pointer unchanged.
- Else, round-robin choice:
  - Scan codes starting at ptr+1 with wrap 12→1, pick the first enabled code, latch it → ISSUE.
  - ptr := picked code.
  - Clear the deadlock counter.
- If no code is enabled:
  - Increment the deadlock counter.
  - When it reaches DEADLOCK_LIMIT: set io_deadlock → HALT.

ISSUE:
- io_en_a = latched code for exactly one cycle.
- io_fired += 1, saturating at all-ones.
- → EVAL unconditionally.

HALT:
- io_en_a=0; terminal until reset.
- io_run and force inputs are ignored.

Forced issues do not move ptr.

## Timing
- io_en_a is registered; no combinational path from inputs to any output.
- Guards are sampled in EVAL only. The core commits the previous rule at the edge ending ISSUE, so EVAL always sees settled state. This gives at most one rule every 2 cycles.
- Latency: inputs sampled at edge k (EVAL) → io_en_a valid during cycle k+1 → core updates at edge k+2.
- io_bad_force is asserted in the cycle after the rejecting EVAL, for one cycle.
- Reset values: io_en_a=0, io_bad_force=0, io_deadlock=0, io_fired=0, ptr=12 (so the first pick scans from code 1), deadlock counter=0, state EVAL.
- Reset asserted mid-ISSUE: io_en_a drops to 0 asynchronously. The core sees no rule.
- io_force_valid with io_run=0: ignored.
- Deadlock counter saturates at DEADLOCK_LIMIT.

## Structure
Shared package holds:
- node-state constants I/T/C/E;
- rule indices Try/Crit/Exit/Idle;
- the code encode/decode function;
- the FSM state enum.

One sub-module, `mutex_guard_eval`: purely combinational. It maps node states and x to a 12-bit enabled vector, bit code-1.

The top level contains the FSM, the round-robin picker, and the counters.

## Test plan
- Reset then io_run=1, n=(I,I,I), x=1:
  - io_en_a sequence 0,1,0,2,0,3 over cycles 1–6, provided the core model is closed-loop.
  - io_fired=3.
- Force code 4 (Crit node 0) with n_0=T, x=1: io_en_a=4 the next cycle; ptr unchanged, so the next free pick follows the prior ptr.
- Force code 4 with x=0: io_bad_force pulses one cycle; io_en_a stays 0; io_fired unchanged.
- Force code 14: io_bad_force pulses; no issue.
- Hold n=(T,T,T), x=0, io_run=1:
  - io_deadlock rises after 4 evaluations;
  - HALT holds io_en_a=0 even if inputs later enable rules;
  - reset clears the flag.
- Assert reset during ISSUE with io_en_a=7: io_en_a=0 immediately; after release, the first pick scans from code 1.
